// File: rtl/cordic_iter_seq.sv
// Iteration sequencer for the CORDIC rotation engine: start/done handshake, stallable steps.
// Define CORDIC_ITER_SEQ_HYPER_EN to enable hyperbolic mode (indices 4 and 13 repeated once).
module cordic_iter_seq #(
    parameter int ITER_W   = 4,
    parameter int MAX_ITER = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [ITER_W-1:0] n_iter,
    input  logic              mode,
    output logic              ready,
    output logic              busy,
    output logic              load,
    output logic              step_valid,
    output logic [ITER_W-1:0] iter,
    output logic              last,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [ITER_W-1:0] cnt_q;
    logic [ITER_W-1:0] iter_q;
    logic [ITER_W-1:0] iter_d;
    logic [ITER_W-1:0] n_q;
    logic [ITER_W-1:0] n_clamped;
    logic [ITER_W-1:0] iter_first;
    logic              final_step;

    assign n_clamped  = (n_iter > ITER_W'(MAX_ITER)) ? ITER_W'(MAX_ITER) : n_iter;
    assign final_step = (cnt_q == n_q - ITER_W'(1));

`ifdef CORDIC_ITER_SEQ_HYPER_EN
    logic mode_q;
    logic rep_q;
    logic rep_d;

    // Hyperbolic convergence needs indices 4 and 13 executed twice in a row.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        iter_d = iter_q + ITER_W'(1);
        rep_d  = 1'b0;
        if (mode_q && !rep_q && (iter_q == ITER_W'(4) || iter_q == ITER_W'(13))) begin
            iter_d = iter_q;
            rep_d  = 1'b1;
        end
    end

    assign iter_first = mode ? ITER_W'(1) : '0;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign iter_d      = iter_q + ITER_W'(1);
    assign iter_first  = '0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            iter_q  <= '0;
            n_q     <= '0;
`ifdef CORDIC_ITER_SEQ_HYPER_EN
            mode_q  <= 1'b0;
            rep_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_q     <= n_clamped;
                        cnt_q   <= '0;
                        iter_q  <= iter_first;
`ifdef CORDIC_ITER_SEQ_HYPER_EN
                        mode_q  <= mode;
                        rep_q   <= 1'b0;
`endif
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_q <= (n_q != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    // On the final step cnt and iter hold so iter reports the last executed index.
                    if (en) begin
                        if (final_step) begin
                            state_q <= S_DONE;
                        end else begin
                            cnt_q  <= cnt_q + ITER_W'(1);
                            iter_q <= iter_d;
`ifdef CORDIC_ITER_SEQ_HYPER_EN
                            rep_q  <= rep_d;
`endif
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready      = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign load       = (state_q == S_LOAD);
    assign step_valid = (state_q == S_RUN) && en;
    assign last       = (state_q == S_RUN) && final_step;
    assign done       = (state_q == S_DONE);
    assign iter       = iter_q;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Self-checking bench for cordic_iter_seq: sequence-level model of expected iteration indices.
module tb_cordic_iter_seq;

    localparam int ITER_W   = 4;
    localparam int MAX_ITER = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              en;
    logic [ITER_W-1:0] n_iter;
    logic              mode;
    logic              ready;
    logic              busy;
    logic              load;
    logic              step_valid;
    logic [ITER_W-1:0] iter;
    logic              last;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    cordic_iter_seq #(
        .ITER_W  (ITER_W),
        .MAX_ITER(MAX_ITER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .en        (en),
        .n_iter    (n_iter),
        .mode      (mode),
        .ready     (ready),
        .busy      (busy),
        .load      (load),
        .step_valid(step_valid),
        .iter      (iter),
        .last      (last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One comparison point for all outputs; exp_iter < 0 means iter is not checked.
    task automatic check_outs(input string tag, input int e_ready, input int e_busy,
                              input int e_load, input int e_sv, input int e_iter,
                              input int e_last, input int e_done);
        check({tag, ".ready"}, int'(ready), e_ready);
        check({tag, ".busy"}, int'(busy), e_busy);
        check({tag, ".load"}, int'(load), e_load);
        check({tag, ".step_valid"}, int'(step_valid), e_sv);
        check({tag, ".last"}, int'(last), e_last);
        check({tag, ".done"}, int'(done), e_done);
        if (e_iter >= 0) check({tag, ".iter"}, int'(iter), e_iter);
    endtask

    function automatic bit hyper_active(input int m);
`ifdef CORDIC_ITER_SEQ_HYPER_EN
        return (m != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Model: the full list of indices an operation must visit.
    function automatic void build_seq(input int n_req, input int m, output int seq[$]);
        int n;
        int idx;
        bit repeated;
        seq      = {};
        n        = (n_req > MAX_ITER) ? MAX_ITER : n_req;
        idx      = hyper_active(m) ? 1 : 0;
        repeated = 1'b0;
        for (int k = 0; k < n; k++) begin
            seq.push_back(idx);
            if (hyper_active(m) && (idx == 4 || idx == 13) && !repeated) begin
                repeated = 1'b1;
            end else begin
                idx++;
                repeated = 1'b0;
            end
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from IDLE; stall_len cycles of en=0 are inserted before step stall_k.
    task automatic run_op(input string tag, input int n_req, input int m,
                          input int stall_k, input int stall_len);
        int seq[$];
        int n;
        int first;
        int final_idx;
        build_seq(n_req, m, seq);
        n         = seq.size();
        first     = hyper_active(m) ? 1 : 0;
        final_idx = (n > 0) ? seq[n-1] : first;

        start  = 1'b1;
        en     = 1'b1;
        n_iter = ITER_W'(n_req);
        mode   = m[0];
        @(negedge clk);
        check_outs({tag, ".idle"}, 1, 0, 0, 0, -1, 0, 0);

        next_cycle();
        start  = 1'b0;
        n_iter = '0;
        mode   = ~m[0];
        @(negedge clk);
        check_outs({tag, ".load"}, 0, 1, 1, 0, first, 0, 0);

        for (int k = 0; k < n; k++) begin
            next_cycle();
            if (k == stall_k) begin
                for (int s = 0; s < stall_len; s++) begin
                    en    = 1'b0;
                    start = 1'b1;
                    @(negedge clk);
                    check_outs({tag, ".stall"}, 0, 1, 0, 0, seq[k], int'(k == n - 1), 0);
                    next_cycle();
                end
                en    = 1'b1;
                start = 1'b0;
            end
            @(negedge clk);
            check_outs($sformatf("%s.step%0d", tag, k), 0, 1, 0, 1, seq[k], int'(k == n - 1), 0);
        end

        next_cycle();
        start = 1'b1;
        @(negedge clk);
        check_outs({tag, ".done"}, 0, 1, 0, 0, final_idx, 0, 1);

        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check_outs({tag, ".after"}, 1, 0, 0, 0, final_idx, 0, 0);
        next_cycle();
    endtask

    task automatic reset_mid_run();
        start  = 1'b1;
        en     = 1'b1;
        n_iter = ITER_W'(13);
        mode   = 1'b0;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        check_outs("rst_mid.load", 0, 1, 1, 0, 0, 0, 0);
        for (int k = 0; k <= 6; k++) begin
            next_cycle();
            if (k == 6) rst = 1'b1;
            @(negedge clk);
            check_outs($sformatf("rst_mid.step%0d", k), 0, 1, 0, 1, k, 0, 0);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_outs("rst_mid.idle", 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        @(negedge clk);
        check_outs("rst_mid.nodone", 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
    endtask

    initial begin
        int seq[$];

        // Hand-computed sequences pin the model itself.
        build_seq(15, 0, seq);
        check("model.clamp_len", seq.size(), 13);
        check("model.clamp_last", seq[12], 12);
        build_seq(0, 0, seq);
        check("model.zero_len", seq.size(), 0);
`ifdef CORDIC_ITER_SEQ_HYPER_EN
        build_seq(6, 1, seq);
        check("model.hyp6_len", seq.size(), 6);
        check("model.hyp6_3", seq[3], 4);
        check("model.hyp6_4", seq[4], 4);
        check("model.hyp6_5", seq[5], 5);
        build_seq(13, 1, seq);
        check("model.hyp13_last", seq[12], 12);
`endif

        rst    = 1'b1;
        start  = 1'b0;
        en     = 1'b1;
        n_iter = '0;
        mode   = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        check_outs("reset", 1, 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_outs("post_reset", 1, 0, 0, 0, 0, 0, 0);
        next_cycle();

        run_op("circ13", 13, 0, -1, 0);
        run_op("stall5", 5, 0, 2, 2);
        run_op("zero", 0, 0, -1, 0);
        run_op("clamp15", 15, 0, 6, 1);
        reset_mid_run();
`ifdef CORDIC_ITER_SEQ_HYPER_EN
        run_op("hyp6", 6, 1, -1, 0);
        run_op("hyp13", 13, 1, 4, 1);
        run_op("hyp_zero", 0, 1, -1, 0);
`endif
        run_op("circ4", 4, 0, -1, 0);
        run_op("circ1", 1, 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_iter_seq.md
Name: cordic_iter_seq

Overview:
- Parametrised iteration sequencer for the CORDIC datapath; replaces the fixed free-running 0..12 stage counter.
- Start/done handshake, runtime iteration count, stall input, load/last/done strobes for the rotation engine and angle-table ROM.
- Optional hyperbolic mode repeats indices 4 and 13, as hyperbolic CORDIC convergence requires.

Parameters:
- ITER_W, 4, width of iteration index, step counter and n_iter; must satisfy 2^ITER_W > MAX_ITER.
- MAX_ITER, 13, maximum steps per operation; larger requests are clamped to this.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request new operation; accepted only when ready=1
- en  in  1  advance enable; 0 stalls RUN with all state held
- n_iter  in  ITER_W  steps requested; sampled on accepted start
- mode  in  1  0 circular, 1 hyperbolic; sampled on accepted start
- ready  out  1  high in IDLE
- busy  out  1  high in LOAD, RUN, DONE
- load  out  1  one-cycle strobe in LOAD: datapath loads operands
- step_valid  out  1  RUN and en: datapath performs step at index iter
- iter  out  ITER_W  current CORDIC shift/ROM index
- last  out  1  RUN and current step is the final one
- done  out  1  one-cycle strobe in DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on rising clk.
- States: IDLE, LOAD, RUN, DONE. Outputs decode from registered state, cnt and iter.
- Reset (rst=1 at edge, any state):
  - state=IDLE, cnt=0, iter=0, rep=0, n_reg=0, mode_reg=0.
  - After reset: ready=1; busy, load, step_valid, last, done=0.
  - Reset mid-operation aborts silently; no done.
- IDLE:
  - start=1: n_reg = min(n_iter, MAX_ITER), mode_reg = mode, cnt=0, rep=0.
  - iter=0, or 1 if hyperbolic active.
  - Go to LOAD.
- LOAD: exactly one cycle, load=1. Next state RUN if n_reg!=0, else DONE (zero-length op, no step_valid).
- RUN:
  - en=0: hold everything; step_valid=0; last still reflects cnt==n_reg-1.
  - en=1 and cnt!=n_reg-1: cnt++, iter advances per index rule.
  - en=1 and cnt==n_reg-1: go to DONE; iter and cnt hold final values.
- DONE: done=1 for one cycle, then IDLE. iter holds the last executed index until next accepted start.
- start ignored outside IDLE, including DONE; earliest restart is the cycle after done.
- Latency: accepted start at edge k gives load at cycle k+1. The n step_valid cycles follow (plus stalls); done comes the cycle after the last step.
- Index rule, circular: iter = cnt, i.e. 0,1,..,n_reg-1.
- Counter widths: cnt never exceeds MAX_ITER-1; no wrap logic needed.

Optional Feature:
- Macro: CORDIC_ITER_SEQ_HYPER_EN.
- Defined, mode_reg=1:
  - iter starts at 1.
  - On each advance: if iter is 4 or 13 and rep==0, hold iter and set rep=1; otherwise iter++ and rep=0.
  - n_reg still counts total steps, repeats included.
- Defined, mode_reg=0: circular rule.
- Not defined: mode port ignored, no rep register, circular rule always.

Test Plan:
- Reset, then start with n_iter=13, mode=0, en=1: load one cycle later; 13 step_valid cycles with iter 0..12; last only with iter=12; done one cycle after, then ready=1.
- n_iter=5, en low for 2 cycles at iter=2: iter holds 2 and step_valid=0 during stall; exactly 5 steps total; done after iter=4.
- n_iter=0: load then done on the next cycle; no step_valid. n_iter=15: clamped to 13 steps.
- start pulsed in RUN and DONE: ignored. rst=1 mid-RUN at iter=6: next cycle IDLE, iter=0, ready=1, no done.
- With CORDIC_ITER_SEQ_HYPER_EN, mode=1, n_iter=6: iter 1,2,3,4,4,5. With n_iter=13: ends at 12, with 4 repeated once.
- With CORDIC_ITER_SEQ_HYPER_EN, mode=0, n_iter=4: iter 0,1,2,3, identical to the build without the macro.
